// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared types and widths for the frame assembler
// Purpose: read FSM state enum and datapath widths used by frame_assembler.
// Ports: none (package).
package frame_pkg;

  localparam int WORD_W  = 16;
  localparam int COUNT_W = 16;

  typedef enum logic {
    PAYLOAD  = 1'b0,
    CHECKSUM = 1'b1
  } state_t;

endpackage

// File: rtl/frame_hold_fifo.sv
// rtl/frame_hold_fifo.sv - single-clock hold FIFO with combinational head
// Purpose: buffers words from the un-backpressured input stream.
// Ports:
//   clock_2        block clock
//   reset          synchronous active-high reset (empties the FIFO)
//   push, wr_data  write request and word; ignored when full unless popping
//   pop            remove the head word (ignored when empty)
//   full, empty    occupancy flags
//   head           word at the read pointer, read straight from memory
module frame_hold_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clock_2,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit tells a full FIFO apart from an empty one.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot, so a full FIFO can still take a word.
  assign do_push = push && (!full || do_pop);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock_2) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock_2) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/frame_assembler.sv
// rtl/frame_assembler.sv - packs a word stream into fixed-length frames
// Purpose: buffers data_2 words in a hold FIFO and emits FRAME_LEN-word frames
//   on a valid/ready output. With FRAME_ASSEMBLER_CHECKSUM_EN defined, each
//   frame is followed by a 16-bit modular sum word carrying out_last; without
//   it, out_last marks the final payload word.
// Ports:
//   clock_2, reset            clock and synchronous active-high reset
//   data_2, data_2_valid      input words, no backpressure
//   out_data, out_valid,
//   out_ready, out_last       output stream (out_data is 0 when not valid)
//   overflow                  sticky flag: a word was dropped on a full FIFO
//   frame_count               completed frames, wraps
module frame_assembler
  import frame_pkg::*;
#(
  parameter int FRAME_LEN  = 4,
  parameter int HOLD_DEPTH = 8
) (
  input  logic               clock_2,
  input  logic               reset,
  input  logic [WORD_W-1:0]  data_2,
  input  logic               data_2_valid,
  output logic [WORD_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               overflow,
  output logic [COUNT_W-1:0] frame_count
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic [WORD_W-1:0] head;
  logic [CNT_W-1:0]  word_cnt;

  frame_hold_fifo #(
    .DEPTH (HOLD_DEPTH),
    .WIDTH (WORD_W)
  ) u_hold_fifo (
    .clock_2 (clock_2),
    .reset   (reset),
    .push    (data_2_valid),
    .wr_data (data_2),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head)
  );

  always_ff @(posedge clock_2) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (data_2_valid && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

`ifdef FRAME_ASSEMBLER_CHECKSUM_EN
  state_t            state;
  state_t            state_next;
  logic [WORD_W-1:0] sum;

  always_ff @(posedge clock_2) begin
    if (reset) begin
      state       <= PAYLOAD;
      sum         <= '0;
      word_cnt    <= '0;
      frame_count <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        sum      <= sum + head;
        word_cnt <= word_cnt + CNT_W'(1);
      end else if (state == CHECKSUM && out_ready) begin
        sum         <= '0;
        word_cnt    <= '0;
        frame_count <= frame_count + COUNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    pop        = 1'b0;
    case (state)
      PAYLOAD: begin
        out_valid = !fifo_empty;
        out_data  = fifo_empty ? '0 : head;
        pop       = !fifo_empty && out_ready;
        if (pop && word_cnt == CNT_W'(FRAME_LEN - 1)) state_next = CHECKSUM;
      end
      CHECKSUM: begin
        out_valid = 1'b1;
        out_data  = sum;
        out_last  = 1'b1;
        if (out_ready) state_next = PAYLOAD;
      end
      default: state_next = PAYLOAD;
    endcase
  end
`else
  always_ff @(posedge clock_2) begin
    if (reset) begin
      word_cnt    <= '0;
      frame_count <= '0;
    end else if (pop) begin
      if (word_cnt == CNT_W'(FRAME_LEN - 1)) begin
        word_cnt    <= '0;
        frame_count <= frame_count + COUNT_W'(1);
      end else begin
        word_cnt <= word_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    out_valid = !fifo_empty;
    out_data  = fifo_empty ? '0 : head;
    out_last  = !fifo_empty && (word_cnt == CNT_W'(FRAME_LEN - 1));
    pop       = !fifo_empty && out_ready;
  end
`endif

endmodule

// File: tb/tb_frame_assembler.sv
// tb/tb_frame_assembler.sv - self-checking bench for frame_assembler
module tb_frame_assembler;

  localparam int L = 4;
  localparam int D = 8;
`ifdef FRAME_ASSEMBLER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int B = L + CK;

  logic        clock_2 = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data_2 = '0;
  logic        data_2_valid = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        overflow;
  logic [15:0] frame_count;

  frame_assembler #(.FRAME_LEN(L), .HOLD_DEPTH(D)) dut (
    .clock_2      (clock_2),
    .reset        (reset),
    .data_2       (data_2),
    .data_2_valid (data_2_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .overflow     (overflow),
    .frame_count  (frame_count)
  );

  always #5 clock_2 = ~clock_2;

  int tests = 0;
  int failed = 0;

  // Reference model: every accepted word in arrival order, plus the index of
  // the next output beat. Beat k belongs to frame k/B at slot k%B; slots below
  // L carry accepted words, slot L (checksum builds only) carries their sum.
  logic [15:0] acc[$];
  int          out_idx;
  logic        m_ovf;
  int          m_frames;
  logic [15:0] last_end_data;

  logic        exp_v, exp_l, exp_ovf;
  logic [15:0] exp_d, exp_fc;
  logic        act_v, act_l, act_ovf;
  logic [15:0] act_d, act_fc;

  function automatic int consumed(input int k);
    return (k / B) * L + (((k % B) < L) ? (k % B) : L);
  endfunction

  task automatic model_expect();
    int f, p, occ;
    f = out_idx / B;
    p = out_idx % B;
    occ = acc.size() - consumed(out_idx);
    exp_v = 1'b0; exp_l = 1'b0; exp_d = '0;
    if (p < L) begin
      if (occ > 0) begin
        exp_v = 1'b1;
        exp_d = acc[f * L + p];
        exp_l = (CK == 0) && (p == L - 1);
      end
    end else begin
      exp_v = 1'b1;
      exp_l = 1'b1;
      for (int i = 0; i < L; i++) exp_d = exp_d + acc[f * L + i];
    end
    exp_ovf = m_ovf;
    exp_fc  = 16'(m_frames);
  endtask

  task automatic model_clear();
    acc.delete();
    out_idx = 0;
    m_ovf = 1'b0;
    m_frames = 0;
  endtask

  // Drives one cycle, captures outputs mid-cycle, computes expectations, and
  // advances the model across the following edge.
  task automatic cycle(input logic dv, input logic [15:0] d, input logic rdy);
    logic hs, payload_pop, drop;
    @(negedge clock_2);
    data_2_valid = dv; data_2 = d; out_ready = rdy;
    #1;
    act_v = out_valid; act_l = out_last; act_d = out_data;
    act_ovf = overflow; act_fc = frame_count;
    model_expect();
    hs = exp_v && rdy;
    payload_pop = hs && ((out_idx % B) < L);
    drop = dv && ((acc.size() - consumed(out_idx)) == D) && !payload_pop;
    if (drop) m_ovf = 1'b1;
    else if (dv) acc.push_back(d);
    if (hs) begin
      if (exp_l) begin
        m_frames++;
        last_end_data = exp_d;
      end
      out_idx++;
    end
    @(posedge clock_2);
  endtask

  task automatic apply_reset();
    @(negedge clock_2);
    reset = 1'b1; data_2_valid = 1'b0; out_ready = 1'b0;
    @(posedge clock_2);
    @(posedge clock_2);
    @(negedge clock_2);
    reset = 1'b0;
    model_clear();
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if ({out_valid, out_last, out_data, overflow, frame_count} !== 34'd0) begin
      failed++;
      $display("FAIL reset_values: got v=%0b l=%0b d=%h ovf=%0b fc=%0d want all zero",
               out_valid, out_last, out_data, overflow, frame_count);
    end
  endtask

  task automatic run_frame(input string name, input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3,
                           input logic [15:0] want_end, input logic [15:0] want_fc);
    logic [15:0] w[4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < B + 3; i++) begin
      cycle(i < 4, (i < 4) ? w[i] : 16'h0, 1'b1);
      tests++;
      if ({act_v, act_l, act_d} !== {exp_v, exp_l, exp_d}) begin
        failed++;
        $display("FAIL %s beat %0d: got v=%0b l=%0b d=%h want v=%0b l=%0b d=%h",
                 name, i, act_v, act_l, act_d, exp_v, exp_l, exp_d);
      end
    end
    tests++;
    if (last_end_data !== want_end) begin
      failed++;
      $display("FAIL %s end_word: got %h want %h", name, last_end_data, want_end);
    end
    tests++;
    if (act_fc !== want_fc) begin
      failed++;
      $display("FAIL %s frame_count: got %0d want %0d", name, act_fc, want_fc);
    end
  endtask

  task automatic test_basic_frame();
    apply_reset();
    run_frame("basic", 16'h0001, 16'h0002, 16'h0003, 16'h0004,
              (CK != 0) ? 16'h000A : 16'h0004, 16'd1);
  endtask

  task automatic test_checksum_wrap();
    run_frame("wrap", 16'hFFFF, 16'h0002, 16'h0000, 16'h0000,
              (CK != 0) ? 16'h0001 : 16'h0000, 16'd2);
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < D + 1; i++) cycle(1'b1, 16'($urandom), 1'b0);
    for (int i = 0; i < 2 * B + 3; i++) begin
      cycle(1'b0, 16'h0, 1'b1);
      tests++;
      if ({act_v, act_l, act_d, act_ovf} !== {exp_v, exp_l, exp_d, 1'b1}) begin
        failed++;
        $display("FAIL overflow_drain beat %0d: got v=%0b l=%0b d=%h ovf=%0b want v=%0b l=%0b d=%h ovf=1",
                 i, act_v, act_l, act_d, act_ovf, exp_v, exp_l, exp_d);
      end
    end
    tests++;
    if (act_fc !== 16'd2) begin
      failed++;
      $display("FAIL overflow_frames: got %0d want 2", act_fc);
    end
  endtask

  task automatic test_full_with_pop();
    apply_reset();
    for (int i = 0; i < D; i++) cycle(1'b1, 16'($urandom), 1'b0);
    cycle(1'b1, 16'h5A5A, 1'b1);
    for (int i = 0; i < 2 * B + 4; i++) begin
      cycle(1'b0, 16'h0, 1'b1);
      tests++;
      if ({act_v, act_l, act_d, act_ovf} !== {exp_v, exp_l, exp_d, 1'b0}) begin
        failed++;
        $display("FAIL full_pop beat %0d: got v=%0b l=%0b d=%h ovf=%0b want v=%0b l=%0b d=%h ovf=0",
                 i, act_v, act_l, act_d, act_ovf, exp_v, exp_l, exp_d);
      end
    end
    tests++;
    if (act_fc !== 16'd2) begin
      failed++;
      $display("FAIL full_pop_frames: got %0d want 2", act_fc);
    end
  endtask

  task automatic test_backpressure_end();
    logic [15:0] w[4];
    logic [15:0] held;
    apply_reset();
    for (int i = 0; i < 4; i++) w[i] = 16'($urandom);
    held = (CK != 0) ? 16'(w[0] + w[1] + w[2] + w[3]) : w[3];
    // B cycles of ready leave exactly the frame's final beat pending.
    for (int i = 0; i < B; i++) cycle(i < 4, (i < 4) ? w[i] : 16'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 16'($urandom), 1'b0);
      tests++;
      if ({act_v, act_l, act_d} !== {1'b1, 1'b1, held}) begin
        failed++;
        $display("FAIL stall_hold cycle %0d: got v=%0b l=%0b d=%h want v=1 l=1 d=%h",
                 i, act_v, act_l, act_d, held);
      end
    end
    for (int i = 0; i < 2 * B + 2; i++) begin
      cycle(1'b0, 16'h0, 1'b1);
      tests++;
      if ({act_v, act_l, act_d} !== {exp_v, exp_l, exp_d}) begin
        failed++;
        $display("FAIL stall_drain beat %0d: got v=%0b l=%0b d=%h want v=%0b l=%0b d=%h",
                 i, act_v, act_l, act_d, exp_v, exp_l, exp_d);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'(16'h0100 + i), 1'b1);
    apply_reset();
    tests++;
    if ({out_valid, out_last, out_data, overflow, frame_count} !== 34'd0) begin
      failed++;
      $display("FAIL midreset_values: got v=%0b l=%0b d=%h ovf=%0b fc=%0d want all zero",
               out_valid, out_last, out_data, overflow, frame_count);
    end
    run_frame("midreset", 16'h0004, 16'h0004, 16'h0004, 16'h0004,
              (CK != 0) ? 16'h0010 : 16'h0004, 16'd1);
  endtask

  task automatic test_random();
    logic dv, rdy;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      dv  = ($urandom_range(0, 3) != 0);
      // Alternate calm and congested stretches so the FIFO fills and drains.
      rdy = ((i / 64) % 3 == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
      cycle(dv, 16'($urandom), rdy);
      tests++;
      if ({act_v, act_l, act_d, act_ovf, act_fc} !== {exp_v, exp_l, exp_d, exp_ovf, exp_fc}) begin
        failed++;
        $display("FAIL random cycle %0d: got v=%0b l=%0b d=%h ovf=%0b fc=%0d want v=%0b l=%0b d=%h ovf=%0b fc=%0d",
                 i, act_v, act_l, act_d, act_ovf, act_fc, exp_v, exp_l, exp_d, exp_ovf, exp_fc);
      end
    end
  endtask

  initial begin
    model_clear();
    last_end_data = '0;
    test_reset();
    test_basic_frame();
    test_checksum_wrap();
    test_overflow();
    test_full_with_pop();
    test_backpressure_end();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
